// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU control unit: opcodes, ALU selects,
// controller states and instruction field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    OP_NOOP  = 4'h0,
    OP_STORE = 4'h1,
    OP_LOAD  = 4'h2,
    OP_ADD   = 4'h3,
    OP_SUB   = 4'h4,
    OP_HALT  = 4'h5
  } opcode_e;

  localparam logic [3:0] ALU_PASS = 4'h0;
  localparam logic [3:0] ALU_ADD  = 4'h1;
  localparam logic [3:0] ALU_SUB  = 4'h2;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_STORE  = 3'd2,
    S_LOAD_A = 3'd3,
    S_LOAD_B = 3'd4,
    S_ALU    = 3'd5,
    S_HALT   = 3'd6
  } state_e;

  // Instruction field positions; LOAD/STORE reuse RW as the data register
  // and the low byte as the data address.
  localparam int OP_MSB    = 15;
  localparam int OP_LSB    = 12;
  localparam int RW_MSB    = 11;
  localparam int RW_LSB    = 8;
  localparam int RA_MSB    = 7;
  localparam int RA_LSB    = 4;
  localparam int RB_MSB    = 3;
  localparam int RB_LSB    = 0;
  localparam int DADDR_MSB = 7;
  localparam int DADDR_LSB = 0;

endpackage

// File: rtl/pc_counter.sv
// Program counter: synchronous reset to zero, increments on inc_en and
// wraps naturally modulo 2^PC_W.
module pc_counter #(
  parameter int PC_W = 7
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inc_en,
  output logic [PC_W-1:0] pc
);

  logic [PC_W-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (inc_en) pc_d = pc_q + PC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) pc_q <= '0;
    else       pc_q <= pc_d;
  end

  assign pc = pc_q;

endmodule

// File: rtl/dp_controller.sv
// Moore control unit: fetches from a synchronous ROM, latches IR in DECODE
// and sequences STORE / LOAD / ALU / HALT, driving every datapath control.
module dp_controller
  import cpu_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int D_ADDR_W = 8,
  parameter int R_ADDR_W = 4,
  parameter int PC_W     = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WIDTH-1:0]    instr,
  output logic [PC_W-1:0]     pc_addr,
  output logic [D_ADDR_W-1:0] D_addr,
  output logic                D_wr,
  output logic                RF_s,
  output logic                RF_W_en,
  output logic [R_ADDR_W-1:0] RF_W_addr,
  output logic [R_ADDR_W-1:0] RF_A_addr,
  output logic [R_ADDR_W-1:0] RF_B_addr,
  output logic [3:0]          ALU_sel,
  output logic                halted
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;
  logic             pc_inc;
  logic [PC_W-1:0]  pc;
  logic [3:0]       dec_op;
  logic [3:0]       ir_op;

  assign dec_op = instr[OP_MSB:OP_LSB];
  assign ir_op  = ir_q[OP_MSB:OP_LSB];

  pc_counter #(.PC_W(PC_W)) u_pc (
    .clk    (clk),
    .reset  (reset),
    .inc_en (pc_inc),
    .pc     (pc)
  );

  // Next-state: the branch out of DECODE looks at the ROM word directly,
  // since IR only captures it on the same edge.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    pc_inc  = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        ir_d   = instr;
        pc_inc = 1'b1;
        case (dec_op)
          OP_STORE:       state_d = S_STORE;
          OP_LOAD:        state_d = S_LOAD_A;
          OP_ADD, OP_SUB: state_d = S_ALU;
          OP_HALT:        state_d = S_HALT;
          default:        state_d = S_FETCH;
        endcase
      end
      S_STORE:  state_d = S_FETCH;
      S_LOAD_A: state_d = S_LOAD_B;
      S_LOAD_B: state_d = S_FETCH;
      S_ALU:    state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Output decode from state and IR only; write enables are masked by reset
  // so an edge that resets can never also commit a write.
  always_comb begin
    D_addr    = '0;
    D_wr      = 1'b0;
    RF_s      = 1'b0;
    RF_W_en   = 1'b0;
    RF_W_addr = '0;
    RF_A_addr = '0;
    RF_B_addr = '0;
    ALU_sel   = ALU_PASS;
    halted    = 1'b0;
    case (state_q)
      S_STORE: begin
        D_addr    = D_ADDR_W'(ir_q[DADDR_MSB:DADDR_LSB]);
        RF_A_addr = R_ADDR_W'(ir_q[RW_MSB:RW_LSB]);
        D_wr      = ~reset;
      end
      S_LOAD_A: D_addr = D_ADDR_W'(ir_q[DADDR_MSB:DADDR_LSB]);
      S_LOAD_B: begin
        D_addr    = D_ADDR_W'(ir_q[DADDR_MSB:DADDR_LSB]);
        RF_s      = 1'b1;
        RF_W_addr = R_ADDR_W'(ir_q[RW_MSB:RW_LSB]);
        RF_W_en   = ~reset;
      end
      S_ALU: begin
        RF_A_addr = R_ADDR_W'(ir_q[RA_MSB:RA_LSB]);
        RF_B_addr = R_ADDR_W'(ir_q[RB_MSB:RB_LSB]);
        RF_W_addr = R_ADDR_W'(ir_q[RW_MSB:RW_LSB]);
        RF_W_en   = ~reset;
        ALU_sel   = (ir_op == OP_SUB) ? ALU_SUB : ALU_ADD;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign pc_addr = pc;

endmodule

// File: tb/tb_dp_controller.sv
// Directed bench for dp_controller with a synchronous ROM model.
module tb_dp_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic [6:0]  pc_addr;
  logic [7:0]  D_addr;
  logic        D_wr, RF_s, RF_W_en, halted;
  logic [3:0]  RF_W_addr, RF_A_addr, RF_B_addr, ALU_sel;

  logic [15:0] rom [128];
  int checks   = 0;
  int failures = 0;

  dp_controller dut (
    .clk       (clk),
    .reset     (reset),
    .instr     (instr),
    .pc_addr   (pc_addr),
    .D_addr    (D_addr),
    .D_wr      (D_wr),
    .RF_s      (RF_s),
    .RF_W_en   (RF_W_en),
    .RF_W_addr (RF_W_addr),
    .RF_A_addr (RF_A_addr),
    .RF_B_addr (RF_B_addr),
    .ALU_sel   (ALU_sel),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  always @(posedge clk) instr <= rom[pc_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic fill_rom(input logic [15:0] v);
    for (int i = 0; i < 128; i++) rom[i] = v;
  endtask

  // Holds reset two edges, releases at a negedge: the DUT is then in FETCH.
  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    logic en_seen;
    reset = 1'b1;
    instr = '0;
    fill_rom(16'h0000);
    rom[0] = 16'h2105;
    rom[1] = 16'h3312;
    rom[2] = 16'h4312;
    rom[3] = 16'h1A7F;
    rom[4] = 16'hF000;
    rom[5] = 16'h5000;

    do_reset();
    chk("rst_pc", 32'(pc_addr), 32'h0);
    chk("rst_en", {D_wr, RF_W_en, halted}, 3'b000);

    step(); // DECODE of LOAD
    chk("ld_dec_pc", 32'(pc_addr), 32'h0);
    chk("ld_dec_en", {D_wr, RF_W_en}, 2'b00);
    step(); // LOAD_A
    chk("ld_a_addr", 32'(D_addr), 32'h05);
    chk("ld_a_en", {D_wr, RF_W_en}, 2'b00);
    chk("ld_a_pc", 32'(pc_addr), 32'h1);
    step(); // LOAD_B
    chk("ld_b_addr", 32'(D_addr), 32'h05);
    chk("ld_b_ctl", {RF_W_en, RF_s, RF_W_addr}, {1'b1, 1'b1, 4'h1});
    step(); // FETCH
    chk("ld_done_pc", 32'(pc_addr), 32'h1);
    chk("ld_done_en", {RF_W_en, D_wr}, 2'b00);

    step(); // DECODE ADD
    chk("add_dec_en", 32'(RF_W_en), 32'h0);
    step(); // ALU
    chk("add_regs", {RF_A_addr, RF_B_addr, RF_W_addr}, 12'h123);
    chk("add_ctl", {ALU_sel, RF_W_en, RF_s, D_wr}, {4'h1, 1'b1, 1'b0, 1'b0});
    step(); // FETCH
    chk("add_after", {ALU_sel, RF_W_en}, {4'h0, 1'b0});
    chk("add_pc", 32'(pc_addr), 32'h2);

    step(); step(); // SUB in ALU
    chk("sub_regs", {RF_A_addr, RF_B_addr, RF_W_addr}, 12'h123);
    chk("sub_ctl", {ALU_sel, RF_W_en, RF_s}, {4'h2, 1'b1, 1'b0});
    step();
    chk("sub_after", 32'(RF_W_en), 32'h0);

    step(); // DECODE STORE
    chk("st_dec", {D_wr, RF_W_en}, 2'b00);
    step(); // STORE
    chk("st_ctl", {D_wr, D_addr, RF_A_addr, RF_W_en}, {1'b1, 8'h7F, 4'hA, 1'b0});
    step(); // FETCH
    chk("st_after", {D_wr, RF_W_en}, 2'b00);
    chk("st_pc", 32'(pc_addr), 32'h4);

    step(); // DECODE 0xF
    chk("ill_dec", {D_wr, RF_W_en}, 2'b00);
    step(); // back in FETCH after 2 cycles
    chk("ill_pc", 32'(pc_addr), 32'h5);
    chk("ill_en", {D_wr, RF_W_en, halted}, 3'b000);

    step(); // DECODE HALT
    chk("halt_dec", 32'(halted), 32'h0);
    step();
    for (int i = 0; i < 20; i++) begin
      chk("halt_hold", {halted, pc_addr, D_wr, RF_W_en}, {1'b1, 7'h6, 1'b0, 1'b0});
      step();
    end
    reset = 1'b1;
    step();
    chk("halt_rst", {halted, pc_addr, D_wr, RF_W_en}, {1'b0, 7'h0, 1'b0, 1'b0});

    // 128 NOOPs: PC must wrap 127 -> 0 with no enables ever raised.
    fill_rom(16'h0000);
    do_reset();
    en_seen = 1'b0;
    for (int i = 0; i < 128; i++) begin
      en_seen |= D_wr | RF_W_en;
      step();
      en_seen |= D_wr | RF_W_en;
      step();
      if (i == 126) chk("wrap_pc127", 32'(pc_addr), 32'd127);
    end
    chk("wrap_pc0", 32'(pc_addr), 32'h0);
    chk("wrap_noen", 32'(en_seen), 32'h0);

    // Reset landing on LOAD_B must suppress the write.
    rom[0] = 16'h2105;
    reset = 1'b1;
    do_reset();
    step(); step(); step(); // LOAD_B
    chk("ldb_pre", {RF_W_en, RF_W_addr}, {1'b1, 4'h1});
    reset = 1'b1;
    #1;
    chk("ldb_rst_en", {RF_W_en, D_wr}, 2'b00);
    step();
    reset = 1'b0;
    chk("ldb_rst_pc", 32'(pc_addr), 32'h0);
    chk("ldb_rst_en2", {RF_W_en, D_wr, halted}, 3'b000);
    step(); // DECODE
    step(); // LOAD_A again from PC 0
    chk("ldb_rerun", {D_addr, pc_addr}, {8'h05, 7'h1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
